// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and round helper functions, used by the schedule
// expansion and compression stages.
package sha256_pkg;

  localparam int W_LENGTH = 64;
  localparam int WORD_W   = 32;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;

  localparam logic [31:0] IV_H0 = 32'h6a09e667;
  localparam logic [31:0] IV_H1 = 32'hbb67ae85;
  localparam logic [31:0] IV_H2 = 32'h3c6ef372;
  localparam logic [31:0] IV_H3 = 32'ha54ff53a;
  localparam logic [31:0] IV_H4 = 32'h510e527f;
  localparam logic [31:0] IV_H5 = 32'h9b05688c;
  localparam logic [31:0] IV_H6 = 32'h1f83d9ab;
  localparam logic [31:0] IV_H7 = 32'h5be0cd19;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Round constants as a ROM lookup
  function automatic logic [31:0] k_const(input logic [5:0] idx);
    case (idx)
      6'd0:  return 32'h428a2f98;  6'd1:  return 32'h71374491;
      6'd2:  return 32'hb5c0fbcf;  6'd3:  return 32'he9b5dba5;
      6'd4:  return 32'h3956c25b;  6'd5:  return 32'h59f111f1;
      6'd6:  return 32'h923f82a4;  6'd7:  return 32'hab1c5ed5;
      6'd8:  return 32'hd807aa98;  6'd9:  return 32'h12835b01;
      6'd10: return 32'h243185be;  6'd11: return 32'h550c7dc3;
      6'd12: return 32'h72be5d74;  6'd13: return 32'h80deb1fe;
      6'd14: return 32'h9bdc06a7;  6'd15: return 32'hc19bf174;
      6'd16: return 32'he49b69c1;  6'd17: return 32'hefbe4786;
      6'd18: return 32'h0fc19dc6;  6'd19: return 32'h240ca1cc;
      6'd20: return 32'h2de92c6f;  6'd21: return 32'h4a7484aa;
      6'd22: return 32'h5cb0a9dc;  6'd23: return 32'h76f988da;
      6'd24: return 32'h983e5152;  6'd25: return 32'ha831c66d;
      6'd26: return 32'hb00327c8;  6'd27: return 32'hbf597fc7;
      6'd28: return 32'hc6e00bf3;  6'd29: return 32'hd5a79147;
      6'd30: return 32'h06ca6351;  6'd31: return 32'h14292967;
      6'd32: return 32'h27b70a85;  6'd33: return 32'h2e1b2138;
      6'd34: return 32'h4d2c6dfc;  6'd35: return 32'h53380d13;
      6'd36: return 32'h650a7354;  6'd37: return 32'h766a0abb;
      6'd38: return 32'h81c2c92e;  6'd39: return 32'h92722c85;
      6'd40: return 32'ha2bfe8a1;  6'd41: return 32'ha81a664b;
      6'd42: return 32'hc24b8b70;  6'd43: return 32'hc76c51a3;
      6'd44: return 32'hd192e819;  6'd45: return 32'hd6990624;
      6'd46: return 32'hf40e3585;  6'd47: return 32'h106aa070;
      6'd48: return 32'h19a4c116;  6'd49: return 32'h1e376c08;
      6'd50: return 32'h2748774c;  6'd51: return 32'h34b0bcb5;
      6'd52: return 32'h391c0cb3;  6'd53: return 32'h4ed8aa4a;
      6'd54: return 32'h5b9cca4f;  6'd55: return 32'h682e6ff3;
      6'd56: return 32'h748f82ee;  6'd57: return 32'h78a5636f;
      6'd58: return 32'h84c87814;  6'd59: return 32'h8cc70208;
      6'd60: return 32'h90befffa;  6'd61: return 32'ha4506ceb;
      6'd62: return 32'hbef9a3f7;  6'd63: return 32'hc67178f2;
      default: return 32'h00000000;
    endcase
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: working registers a..h in,
// next a..h out.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] h,
  input  logic [31:0] k,
  input  logic [31:0] w,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next,
  output logic [31:0] d_next,
  output logic [31:0] e_next,
  output logic [31:0] f_next,
  output logic [31:0] g_next,
  output logic [31:0] h_next
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
  assign t2 = big_sigma0(a) + maj(a, b, c);

  assign a_next = t1 + t2;
  assign b_next = a;
  assign c_next = b;
  assign d_next = c;
  assign e_next = d + t1;
  assign f_next = e;
  assign g_next = f;
  assign h_next = g;

endmodule

// File: rtl/sha256_compress_rounds.sv
// Iterative SHA-256 compression: 64 rounds at one per clock, then the
// chaining-hash feed-forward add with a one-cycle done pulse.
module sha256_compress_rounds
  import sha256_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          w_complete,
  input  logic [W_LENGTH*WORD_W-1:0]    w_vector,
  input  logic [8*WORD_W-1:0]           hash_in,
  output logic                          busy,
  output logic                          done,
  output logic [8*WORD_W-1:0]           hash_out
);

  logic [1:0]   state;
  logic [5:0]   rnd;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [255:0] h_save;
  logic [31:0]  w_t;
  logic [31:0]  k_t;
  logic [31:0]  a_n, b_n, c_n, d_n, e_n, f_n, g_n, h_n;
  logic [255:0] work;

  assign w_t  = w_vector[{rnd, 5'd0} +: 32];
  assign k_t  = k_const(rnd);
  assign work = {h, g, f, e, d, c, b, a};

  sha256_round u_round (
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .k(k_t), .w(w_t),
    .a_next(a_n), .b_next(b_n), .c_next(c_n), .d_next(d_n),
    .e_next(e_n), .f_next(f_n), .g_next(g_n), .h_next(h_n)
  );

  // FSM, round counter, working registers and feed-forward output register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      rnd      <= 6'd0;
      {h, g, f, e, d, c, b, a} <= 256'd0;
      h_save   <= 256'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      hash_out <= 256'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && w_complete) begin
            h_save <= hash_in;
            {h, g, f, e, d, c, b, a} <= hash_in;
            rnd    <= 6'd0;
            busy   <= 1'b1;
            state  <= ROUND;
          end
        end
        ROUND: begin
          {h, g, f, e, d, c, b, a} <= {h_n, g_n, f_n, e_n, d_n, c_n, b_n, a_n};
          rnd <= rnd + 6'd1;
          if (rnd == 6'd63) begin
            state <= FINAL;
          end
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) begin
            hash_out[32*i +: 32] <= h_save[32*i +: 32] + work[32*i +: 32];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_compress_rounds.sv
// Directed and randomised self-checking bench for sha256_compress_rounds.
module tb_sha256_compress_rounds;
  import sha256_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          w_complete;
  logic [2047:0] w_vector;
  logic [255:0]  hash_in;
  logic          busy;
  logic          done;
  logic [255:0]  hash_out;

  int errors = 0;
  int checks = 0;

  sha256_compress_rounds dut (
    .clock(clock), .reset(reset), .start(start), .w_complete(w_complete),
    .w_vector(w_vector), .hash_in(hash_in), .busy(busy), .done(done),
    .hash_out(hash_out)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] pack8(input logic [31:0] h0, h1, h2, h3, h4, h5, h6, h7);
    return {h7, h6, h5, h4, h3, h2, h1, h0};
  endfunction

  // Message schedule from a 16-word block (W_t at bits [32t+31:32t])
  function automatic logic [2047:0] expand(input logic [511:0] blk);
    logic [31:0] wt [64];
    logic [2047:0] v;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) wt[t] = blk[32*t +: 32];
      else wt[t] = (rr(wt[t-2], 17) ^ rr(wt[t-2], 19) ^ (wt[t-2] >> 10)) + wt[t-7]
                 + (rr(wt[t-15], 7) ^ rr(wt[t-15], 18) ^ (wt[t-15] >> 3)) + wt[t-16];
      v[32*t +: 32] = wt[t];
    end
    return v;
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [2047:0] wv);
    logic [31:0] r [8];
    logic [31:0] t1, t2;
    logic [255:0] res;
    for (int i = 0; i < 8; i++) r[i] = hin[32*i +: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = r[7] + (rr(r[4], 6) ^ rr(r[4], 11) ^ rr(r[4], 25)) + ((r[4] & r[5]) ^ (~r[4] & r[6]))
         + k_const(6'(t)) + wv[32*t +: 32];
      t2 = (rr(r[0], 2) ^ rr(r[0], 13) ^ rr(r[0], 22)) + ((r[0] & r[1]) ^ (r[0] & r[2]) ^ (r[1] & r[2]));
      r[7] = r[6]; r[6] = r[5]; r[5] = r[4]; r[4] = r[3] + t1;
      r[3] = r[2]; r[2] = r[1]; r[1] = r[0]; r[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[32*i +: 32] = hin[32*i +: 32] + r[i];
    return res;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one block, then count cycles from the accepting edge to done
  task automatic run_block(input logic [255:0] hin, input logic [2047:0] wv, output int lat);
    w_vector = wv; hash_in = hin; start = 1'b1; w_complete = 1'b1;
    @(negedge clock);
    start = 1'b0;
    hash_in = ~hin;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clock);
      lat++;
    end
  endtask

  logic [255:0]  iv, abc_dig, two_dig, mid, exp_h;
  logic [511:0]  blk;
  logic [2047:0] abc_w, m1_w, m2_w, rnd_w;
  int lat, ndone, first_done;

  initial begin
    iv      = pack8(IV_H0, IV_H1, IV_H2, IV_H3, IV_H4, IV_H5, IV_H6, IV_H7);
    abc_dig = pack8(32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad);
    two_dig = pack8(32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                    32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1);
    blk = 512'd0; blk[31:0] = 32'h61626380; blk[511:480] = 32'h00000018;
    abc_w = expand(blk);
    blk = 512'd0;
    blk[32*0 +: 32] = 32'h61626364;  blk[32*1 +: 32] = 32'h62636465;
    blk[32*2 +: 32] = 32'h63646566;  blk[32*3 +: 32] = 32'h64656667;
    blk[32*4 +: 32] = 32'h65666768;  blk[32*5 +: 32] = 32'h66676869;
    blk[32*6 +: 32] = 32'h6768696a;  blk[32*7 +: 32] = 32'h68696a6b;
    blk[32*8 +: 32] = 32'h696a6b6c;  blk[32*9 +: 32] = 32'h6a6b6c6d;
    blk[32*10 +: 32] = 32'h6b6c6d6e; blk[32*11 +: 32] = 32'h6c6d6e6f;
    blk[32*12 +: 32] = 32'h6d6e6f70; blk[32*13 +: 32] = 32'h6e6f7071;
    blk[32*14 +: 32] = 32'h80000000;
    m1_w = expand(blk);
    blk = 512'd0; blk[511:480] = 32'h000001c0;
    m2_w = expand(blk);

    reset = 1'b0; start = 1'b0; w_complete = 1'b0; w_vector = 2048'd0; hash_in = 256'd0;
    repeat (2) @(negedge clock);
    chk("reset_busy", {255'd0, busy}, 256'd0);
    chk("reset_done", {255'd0, done}, 256'd0);
    chk("reset_hash", hash_out, 256'd0);
    reset = 1'b1;

    // start without a ready schedule is ignored
    start = 1'b1; w_complete = 1'b0; w_vector = abc_w; hash_in = iv; ndone = 0; lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (busy === 1'b1) lat++;
      if (done === 1'b1) ndone++;
    end
    start = 1'b0;
    chk("notready_busy", 256'(lat), 256'd0);
    chk("notready_done", 256'(ndone), 256'd0);
    chk("notready_hash", hash_out, 256'd0);

    // abc block
    run_block(iv, abc_w, lat);
    chk("abc_latency", 256'(lat), 256'd65);
    chk("abc_digest", hash_out, abc_dig);
    chk("abc_busy_at_done", {255'd0, busy}, 256'd0);
    @(negedge clock);
    chk("abc_done_width", {255'd0, done}, 256'd0);
    chk("abc_hash_hold", hash_out, abc_dig);

    // two-block chaining
    run_block(iv, m1_w, lat);
    chk("blk1_latency", 256'(lat), 256'd65);
    mid = hash_out;
    chk("blk1_model", mid, compress(iv, m1_w));
    @(negedge clock);
    chk("blk1_done_width", {255'd0, done}, 256'd0);
    run_block(mid, m2_w, lat);
    chk("blk2_latency", 256'(lat), 256'd65);
    chk("two_block_digest", hash_out, two_dig);
    @(negedge clock);
    chk("blk2_done_width", {255'd0, done}, 256'd0);

    // start pulses while busy are ignored
    w_vector = abc_w; hash_in = iv; start = 1'b1; w_complete = 1'b1;
    @(negedge clock);
    start = 1'b0; hash_in = 256'd0; ndone = 0; first_done = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      start = (cyc == 10 || cyc == 40) ? 1'b1 : 1'b0;
      @(negedge clock);
      if (done === 1'b1) begin
        ndone++;
        if (first_done == 0) first_done = cyc;
      end
    end
    start = 1'b0;
    chk("busy_start_dones", 256'(ndone), 256'd1);
    chk("busy_start_latency", 256'(first_done), 256'd65);
    chk("busy_start_digest", hash_out, abc_dig);
    chk("busy_start_idle", {255'd0, busy}, 256'd0);

    // reset in the middle of a block
    w_vector = abc_w; hash_in = iv; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (30) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_busy", {255'd0, busy}, 256'd0);
    chk("midrst_done", {255'd0, done}, 256'd0);
    chk("midrst_hash", hash_out, 256'd0);
    reset = 1'b1;
    @(negedge clock);
    run_block(iv, abc_w, lat);
    chk("midrst_abc_latency", 256'(lat), 256'd65);
    chk("midrst_abc_digest", hash_out, abc_dig);

    // back-to-back random blocks with start held high
    @(negedge clock);
    start = 1'b1; w_complete = 1'b1;
    for (int j = 0; j < 100; j++) begin
      for (int i = 0; i < 64; i++) rnd_w[32*i +: 32] = $urandom();
      for (int i = 0; i < 8; i++) hash_in[32*i +: 32] = $urandom();
      w_vector = rnd_w;
      exp_h = compress(hash_in, rnd_w);
      lat = 0;
      do begin
        @(negedge clock);
        lat++;
      end while (done !== 1'b1 && lat < 150);
      chk($sformatf("rand%0d_spacing", j), 256'(lat), 256'd66);
      chk($sformatf("rand%0d_digest", j), hash_out, exp_h);
    end
    start = 1'b0;
    @(negedge clock);
    chk("rand_end_done", {255'd0, done}, 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
